// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// One radix-2 step on magnitudes: shift-add for multiply, restoring shift-subtract for divide.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic             fits;
    logic [WIDTH-1:0] rem;

    always_comb begin
        sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
        shl    = {hi_in, lo_in[WIDTH-1]};
        fits   = (shl >= {1'b0, opnd});
        // a successful subtract always leaves a value below opnd, so WIDTH bits suffice
        rem    = shl[WIDTH-1:0] - opnd;
        hi_out = '0;
        lo_out = '0;
        if (is_div) begin
            hi_out = fits ? rem : shl[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], fits};
        end else begin
            {hi_out, lo_out} = {sum, lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with architectural HI/LO registers.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state, state_nxt;
    logic             launch, calc_en, commit;
    logic [CW-1:0]    cnt;

    mdu_op_e          op_in, op_r;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_r;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic             neg_res, neg_rem;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, res_hi, res_lo;
    logic               dbz;

    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r, dbz_r;

    assign launch = (state == ST_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_CALC;
            ST_CALC: begin
                if (abort)                       state_nxt = ST_IDLE;
                else if (cnt == CW'(WIDTH - 1))  state_nxt = ST_FIN;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        calc_en = (state == ST_CALC) && !abort;
        commit  = (state == ST_FIN) && !abort;
    end

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        op_in = mdu_op_e'(op);
        sa    = op_is_signed(op_in) && a[WIDTH-1];
        sb    = op_is_signed(op_in) && b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div (op_is_div(op_r)),
        .hi_in  (acc_hi),
        .lo_in  (acc_lo),
        .opnd   (opnd),
        .hi_out (it_hi),
        .lo_out (it_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            a_r     <= '0;
            op_r    <= OP_MULT;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
        end else if (launch) begin
            acc_hi  <= '0;
            acc_lo  <= mag_a;
            opnd    <= mag_b;
            a_r     <= a;
            op_r    <= op_in;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            cnt     <= '0;
        end else if (calc_en) begin
            acc_hi  <= it_hi;
            acc_lo  <= it_lo;
            cnt     <= cnt + 1'b1;
        end
    end

    // Sign fix-up: quotient/product negated on sign mismatch, remainder follows the dividend.
    always_comb begin
        prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        q_fix    = neg_res ? -acc_lo : acc_lo;
        r_fix    = neg_rem ? -acc_hi : acc_hi;
        dbz      = op_is_div(op_r) && (opnd == '0);
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (dbz) begin
            res_hi = a_r;
            res_lo = '1;
        end else if (op_is_div(op_r)) begin
            res_hi = r_fix;
            res_lo = q_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= commit;
            dbz_r  <= commit && dbz;
            if (commit) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
            end else if ((state == ST_IDLE) && !start) begin
                if (hi_we) hi_r <= wdata;
                if (lo_we) lo_r <= wdata;
            end
        end
    end

    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table plus random back-to-back ops through a scoreboard, then corner sequences.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[11];
    int   checks = 0, errors = 0;
    int   t0 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic signed [63:0] sx, sy, p;
        logic [63:0] up;
        e = '0;
        case (o)
            2'b00: begin sx = $signed(x); sy = $signed(y); p = sx * sy; {e.hi, e.lo} = p; end
            2'b01: begin up = {32'b0, x} * {32'b0, y}; {e.hi, e.lo} = up; end
            default: begin
                if (y == '0) begin
                    e.hi = x; e.lo = '1; e.dbz = 1'b1;
                end else if (o == 2'b11) begin
                    e.lo = x / y; e.hi = x % y;
                end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    e.lo = x; e.hi = '0;
                end else begin
                    e.lo = $signed(x) / $signed(y); e.hi = $signed(x) % $signed(y);
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following the start edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        op = o; a = x; b = y; start = 1'b1;
        sb_q.push_back(e);
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        exp_t e;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout waiting for done", nm);
        end else begin
            chk({nm, "_lat"}, 64'(cyc - t0), 64'(W + 1));
            chk({nm, "_busy"}, 64'(busy), 64'd0);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({nm, "_hi"}, 64'(hi), 64'(e.hi));
            chk({nm, "_lo"}, 64'(lo), 64'(e.lo));
            chk({nm, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        end else begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", nm);
        end
    endtask

    initial begin
        exp_t e;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        int dcnt;

        vt[0]  = '{2'b00, 32'd3,          32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vt[1]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[2]  = '{2'b10, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[4]  = '{2'b11, 32'd7,          32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1};
        vt[5]  = '{2'b10, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vt[6]  = '{2'b10, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vt[7]  = '{2'b00, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vt[8]  = '{2'b11, 32'd100,        32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vt[9]  = '{2'b01, 32'h00010000,   32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vt[10] = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);

        // first start is presented in the same cycle reset releases
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            launch(vt[i].op, vt[i].a, vt[i].b, '{vt[i].hi, vt[i].lo, vt[i].dbz});
            wait_done($sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), 64'(done), 64'd0);
        end

        // random ops, each launched in the done cycle of the previous one
        ro = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
        launch(ro, ra, rb, model(ro, ra, rb));
        for (int k = 0; k < 8; k++) begin
            wait_done($sformatf("rnd%0d", k));
            if (k < 7) begin
                ro = 2'($urandom_range(0, 3));
                ra = $urandom;
                rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
                launch(ro, ra, rb, model(ro, ra, rb));
            end
        end
        @(negedge clk);

        // start + direct writes while busy are both dropped
        launch(2'b00, 32'd3, 32'hFFFFFFFB, '{32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        chk("busy_held", 64'(busy), 64'd1);
        wait_done("busy_ign");
        @(negedge clk);
        chk("busy_norestart", 64'(busy), 64'd0);

        // abort mid-calculation
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'hFFFFFFFF);
        chk("abort_lo", 64'(lo), 64'hFFFFFFF1);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("abort_quiet", 64'(dcnt), 64'd0);

        // abort together with start in IDLE suppresses the launch
        op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", 64'(busy), 64'd0);
        chk("abst_lo", 64'(lo), 64'hFFFFFFF1);

        // direct HI/LO writes in IDLE
        lo_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h12345678);
        chk("mtlo_hi", 64'(hi), 64'hFFFFFFFF);
        hi_we = 1'b1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hCAFEF00D);
        chk("mthi_lo", 64'(lo), 64'h12345678);

        // write alongside start is dropped
        hi_we = 1'b1; wdata = 32'h00001111;
        launch(2'b01, 32'd2, 32'd3, '{32'd0, 32'd6, 1'b0});
        hi_we = 1'b0;
        chk("mthi_start_drop", 64'(hi), 64'hCAFEF00D);
        wait_done("after_mt");
        @(negedge clk);

        // asynchronous reset mid-operation, then a fresh op
        op = 2'b10; a = 32'hFFFFFF9C; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_hi", 64'(hi), 64'd0);
        chk("mrst_lo", 64'(lo), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e = model(2'b00, 32'hFFFFFFFD, 32'd7);
        launch(2'b00, 32'hFFFFFFFD, 32'd7, e);
        wait_done("post_rst");
        chk("post_rst_lo_const", 64'(lo), 64'hFFFFFFEB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, operand/result width; legal values are even and 8..64.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  launch request, sampled only in IDLE.
REQ-005 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 a  in  WIDTH  multiplicand or dividend; sampled with start.
REQ-007 b  in  WIDTH  multiplier or divisor; sampled with start.
REQ-008 abort  in  1  cancels an in-flight operation.
REQ-009 hi_we, lo_we  in  1 each  MTHI/MTLO direct write strobes.
REQ-010 wdata  in  WIDTH  MTHI/MTLO write data.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 done  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
REQ-013 div_by_zero  out  1  valid with done; high when a DIV/DIVU had b==0.
REQ-014 hi, lo  out  WIDTH each  architectural HI/LO registers.

Function
REQ-015 The FSM SHALL have states IDLE, CALC, FIN: IDLE->CALC on start; CALC->FIN after exactly WIDTH iterations; FIN->IDLE unconditionally.
REQ-016 CALC SHALL perform one radix-2 iteration per cycle on operand magnitudes: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 FIN SHALL apply the sign fix-up, write HI/LO, and register done=1 for the following cycle.
REQ-018 Latency from the start edge to the edge that writes HI/LO SHALL be WIDTH+1 cycles.
REQ-019 busy SHALL be low in the done cycle, so a new start is accepted in that cycle.
REQ-020 MULT/MULTU SHALL produce the full 2*WIDTH-bit product: HI = upper half, LO = lower half.
REQ-021 MULT SHALL treat a and b as two's complement; MULTU SHALL treat them as unsigned.
REQ-022 DIV/DIVU SHALL return LO = quotient and HI = remainder.
REQ-023 DIV SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-024 DIV of the most-negative value by -1 SHALL give LO = most-negative value, HI = 0, and no flag.
REQ-025 For a divide with b==0: LO = all ones, HI = a (unmodified), div_by_zero = 1; the cycle count is unchanged.
REQ-026 start while busy SHALL be ignored.
REQ-027 hi_we/lo_we SHALL write HI/LO at the next edge only when state==IDLE and start==0; otherwise the write is dropped.
REQ-028 abort in CALC or FIN SHALL return to IDLE at the next edge with HI/LO unchanged and no done pulse.
REQ-029 abort in IDLE SHALL have no effect; abort together with start in IDLE SHALL suppress the start.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE and hi=lo=0, and busy=done=div_by_zero=0, including mid-operation.
REQ-031 After rst_n deasserts, start SHALL be accepted from the first rising edge.

Structure
REQ-032 Op encodings (MULT, MULTU, DIV, DIVU) and the FSM state enum SHALL live in shared package mdu_pkg.
REQ-033 The per-iteration add/subtract-and-shift datapath SHALL be a single sub-module, mdu_iter, parameterised by WIDTH; the FSM, counter, sign handling and HI/LO registers stay in mul_div_unit.

Verification
REQ-034 Bench SHALL cover these directed scenarios with WIDTH=32:
- MULT a=3, b=-5 -> done 33 cycles after start; HI=FFFFFFFF, LO=FFFFFFF1.
- MULTU a=b=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- DIV a=-7, b=2 -> LO=FFFFFFFD, HI=FFFFFFFF; then DIV a=80000000, b=FFFFFFFF -> LO=80000000, HI=0, div_by_zero=0.
- DIVU a=7, b=0 -> LO=FFFFFFFF, HI=00000007, div_by_zero=1.
- Start plus lo_we while busy -> both ignored, original result lands; abort at iteration 10 -> busy low next cycle, no done, HI/LO unchanged; lo_we=1, wdata=12345678 in IDLE -> lo=12345678.
- rst_n low at iteration 5 -> hi=lo=0 and busy=0 immediately; a fresh start after reset completes normally.
